// File: rtl/chipper3d_pipe_router.sv
// chipper3d_pipe_router
//   Pipelined bufferless deflection router for one node of a 3D mesh.
//   Six link ports (N,S,E,W,U,D) use YZX dimension-order routing with
//   oldest-first allocation. The local PE gets one ejection per cycle and
//   injects through a small valid/ready FIFO.
//
//   Flit layout, MSB first: {vld, age[AGE_W], X[CW], Y[CW], Z[CW], payload[PW]}
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   n_in .. d_in   [FW-1:0]  inbound link flits (vld=0 is an empty slot)
//   n_out .. d_out [FW-1:0]  outbound link flits, registered
//   pe_in_flit     [FW-2:0]  flit to inject; its age field is ignored
//   pe_in_valid / pe_in_ready  injection handshake
//   pe_out_flit    [FW-1:0]  ejected flit, registered
//   pe_out_valid             pe_out_flit holds a flit this cycle
//
// Pipeline: inputs -> stage 1 (eject/inject) -> s1 registers -> stage 2
// (port allocation, age increment) -> output registers.

// Flit-count conservation checker: every flit either stays in the pipeline
// or leaves through ejection, and injection adds exactly one.
module chipper3d_pipe_router_chk (
  input logic       clk,
  input logic       rst,
  input logic [5:0] in_vld,
  input logic [5:0] slot_vld,
  input logic       ej,
  input logic       inj,
  input logic [5:0] s1_vld,
  input logic [5:0] out_vld
);

  function automatic logic [3:0] count6(input logic [5:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 6; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

  // Conservation across stage 1 and stage 2 at every active edge.
  always @(posedge clk) begin
    if (!rst) begin
      assert (count6(slot_vld) + {3'b000, ej} == count6(in_vld) + {3'b000, inj});
      assert (count6(out_vld) == count6(s1_vld));
    end
  end

endmodule

module chipper3d_pipe_router #(
  parameter int            CW        = 2,
  parameter int            PW        = 16,
  parameter int            AGE_W     = 4,
  parameter logic [CW-1:0] XN        = '0,
  parameter logic [CW-1:0] YN        = '0,
  parameter logic [CW-1:0] ZN        = '0,
  parameter int            INJ_DEPTH = 4,
  localparam int           FW        = 1 + AGE_W + 3*CW + PW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [FW-1:0] n_in,
  input  logic [FW-1:0] s_in,
  input  logic [FW-1:0] e_in,
  input  logic [FW-1:0] w_in,
  input  logic [FW-1:0] u_in,
  input  logic [FW-1:0] d_in,
  output logic [FW-1:0] n_out,
  output logic [FW-1:0] s_out,
  output logic [FW-1:0] e_out,
  output logic [FW-1:0] w_out,
  output logic [FW-1:0] u_out,
  output logic [FW-1:0] d_out,
  input  logic [FW-2:0] pe_in_flit,
  input  logic          pe_in_valid,
  output logic          pe_in_ready,
  output logic [FW-1:0] pe_out_flit,
  output logic          pe_out_valid
);

  // Field offsets inside a flit.
  localparam int ZL    = PW;
  localparam int YL    = PW + CW;
  localparam int XL    = PW + 2*CW;
  localparam int AL    = PW + 3*CW;
  localparam int VB    = FW - 1;
  localparam int PTR_W = $clog2(INJ_DEPTH);
  localparam int CNT_W = $clog2(INJ_DEPTH + 1);

  localparam logic [AGE_W-1:0] AGE_MAX   = {AGE_W{1'b1}};
  localparam logic [2:0]       PORT_NONE = 3'd6;

  typedef logic [FW-1:0] flit_t;

  function automatic logic [AGE_W-1:0] age_of(input flit_t f);
    return f[AL +: AGE_W];
  endfunction

  function automatic logic is_local(input flit_t f);
    return (f[XL +: CW] == XN) && (f[YL +: CW] == YN) && (f[ZL +: CW] == ZN);
  endfunction

  // YZX order: port index N=0,S=1,E=2,W=3,U=4,D=5; PORT_NONE when already home.
  function automatic logic [2:0] prod_port(input flit_t f);
    logic [2:0] p;
    if (f[YL +: CW] > YN) begin
      p = 3'd0;
    end else if (f[YL +: CW] < YN) begin
      p = 3'd1;
    end else if (f[ZL +: CW] > ZN) begin
      p = 3'd4;
    end else if (f[ZL +: CW] < ZN) begin
      p = 3'd5;
    end else if (f[XL +: CW] > XN) begin
      p = 3'd2;
    end else if (f[XL +: CW] < XN) begin
      p = 3'd3;
    end else begin
      p = PORT_NONE;
    end
    return p;
  endfunction

  function automatic flit_t age_inc(input flit_t f);
    flit_t r;
    r = f;
    if (age_of(f) != AGE_MAX) begin
      r[AL +: AGE_W] = age_of(f) + AGE_W'(1);
    end else begin
      r[AL +: AGE_W] = AGE_MAX;
    end
    return r;
  endfunction

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    logic [PTR_W-1:0] n;
    if (p == PTR_W'(INJ_DEPTH - 1)) begin
      n = {PTR_W{1'b0}};
    end else begin
      n = p + PTR_W'(1);
    end
    return n;
  endfunction

  flit_t            in_s   [6];
  flit_t            slot_s [6];
  flit_t            s1_r   [6];
  flit_t            out_s  [6];
  flit_t            out_r  [6];
  flit_t            ej_flit_s;
  flit_t            pe_out_flit_r;
  logic             pe_out_valid_r;
  logic             ej_found_s;
  logic [2:0]       ej_idx_s;
  logic [AGE_W-1:0] ej_age_s;
  logic             free_found_s;
  logic [2:0]       free_idx_s;
  logic             inj_s;

  logic [AL-1:0]    fifo_mem_r [INJ_DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  logic [2:0]       rank_s [6];
  logic [5:0]       busy_s;
  logic [2:0]       prod_s;
  logic [2:0]       port_s;
  logic             got_s;

  logic [5:0]       in_vld_s;
  logic [5:0]       slot_vld_s;
  logic [5:0]       s1_vld_s;
  logic [5:0]       out_vld_s;

  // The injected flit's age is always forced to zero, so those bits are dropped.
  logic             age_unused_s;
  assign age_unused_s = ^pe_in_flit[FW-2:AL];

  assign in_s[0] = n_in;
  assign in_s[1] = s_in;
  assign in_s[2] = e_in;
  assign in_s[3] = w_in;
  assign in_s[4] = u_in;
  assign in_s[5] = d_in;

  // Ready looks only at occupancy, so a full FIFO refuses a push even if it pops.
  assign pe_in_ready = (count_r < CNT_W'(INJ_DEPTH)) && !rst;
  assign push_s      = pe_in_valid && pe_in_ready;
  assign pop_s       = inj_s;

  // Stage 1: oldest local flit ejects, then the FIFO head fills the lowest empty slot.
  always_comb begin
    ej_found_s   = 1'b0;
    ej_idx_s     = 3'd0;
    ej_age_s     = {AGE_W{1'b0}};
    ej_flit_s    = {FW{1'b0}};
    free_found_s = 1'b0;
    free_idx_s   = 3'd0;
    inj_s        = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (in_s[i][VB]) begin
        slot_s[i] = in_s[i];
      end else begin
        slot_s[i] = {FW{1'b0}};
      end
    end
    // Strict '>' keeps the lowest port index on an age tie.
    for (int i = 0; i < 6; i++) begin
      if (in_s[i][VB] && is_local(in_s[i]) && (!ej_found_s || (age_of(in_s[i]) > ej_age_s))) begin
        ej_found_s = 1'b1;
        ej_idx_s   = 3'(i);
        ej_age_s   = age_of(in_s[i]);
      end else begin
        ej_found_s = ej_found_s;
      end
    end
    if (ej_found_s) begin
      ej_flit_s        = in_s[ej_idx_s];
      slot_s[ej_idx_s] = {FW{1'b0}};
    end else begin
      ej_flit_s = {FW{1'b0}};
    end
    for (int i = 0; i < 6; i++) begin
      if (!free_found_s && !slot_s[i][VB]) begin
        free_found_s = 1'b1;
        free_idx_s   = 3'(i);
      end else begin
        free_found_s = free_found_s;
      end
    end
    // Ejection runs first, so a freshly injected self-addressed flit waits a lap.
    inj_s = (count_r != {CNT_W{1'b0}}) && free_found_s;
    if (inj_s) begin
      slot_s[free_idx_s] = {1'b1, {AGE_W{1'b0}}, fifo_mem_r[rd_ptr_r]};
    end else begin
      inj_s = 1'b0;
    end
  end

  // Stage 2 priority: rank = number of valid flits that are older, or equally old in a lower slot.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      rank_s[i] = 3'd0;
      for (int j = 0; j < 6; j++) begin
        if (s1_r[j][VB] && ((age_of(s1_r[j]) > age_of(s1_r[i])) ||
            ((age_of(s1_r[j]) == age_of(s1_r[i])) && (j < i)))) begin
          rank_s[i] = rank_s[i] + 3'd1;
        end else begin
          rank_s[i] = rank_s[i];
        end
      end
    end
  end

  // Stage 2 allocation: in rank order, productive port if free, else first free port.
  always_comb begin
    busy_s = 6'b000000;
    prod_s = PORT_NONE;
    port_s = 3'd0;
    got_s  = 1'b0;
    for (int i = 0; i < 6; i++) begin
      out_s[i] = {FW{1'b0}};
    end
    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < 6; i++) begin
        if (s1_r[i][VB] && (rank_s[i] == 3'(p))) begin
          prod_s = prod_port(s1_r[i]);
          port_s = 3'd0;
          got_s  = 1'b0;
          if ((prod_s != PORT_NONE) && !busy_s[prod_s]) begin
            port_s = prod_s;
            got_s  = 1'b1;
          end else begin
            for (int q = 0; q < 6; q++) begin
              if (!got_s && !busy_s[q]) begin
                port_s = 3'(q);
                got_s  = 1'b1;
              end else begin
                got_s = got_s;
              end
            end
          end
          // At most six flits compete for six ports, so got_s is always set here.
          busy_s[port_s] = 1'b1;
          out_s[port_s]  = age_inc(s1_r[i]);
        end else begin
          got_s = got_s;
        end
      end
    end
  end

  // Pipeline registers: stage-1 slots, ejection port and link outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        s1_r[i]  <= {FW{1'b0}};
        out_r[i] <= {FW{1'b0}};
      end
      pe_out_flit_r  <= {FW{1'b0}};
      pe_out_valid_r <= 1'b0;
    end else begin
      for (int i = 0; i < 6; i++) begin
        s1_r[i]  <= slot_s[i];
        out_r[i] <= out_s[i];
      end
      pe_out_flit_r  <= ej_flit_s;
      pe_out_valid_r <= ej_found_s;
    end
  end

  // Injection FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Injection FIFO storage; entries are only read below the occupancy count.
  always_ff @(posedge clk) begin
    if (push_s) begin
      fifo_mem_r[wr_ptr_r] <= pe_in_flit[AL-1:0];
    end
  end

  assign n_out        = out_r[0];
  assign s_out        = out_r[1];
  assign e_out        = out_r[2];
  assign w_out        = out_r[3];
  assign u_out        = out_r[4];
  assign d_out        = out_r[5];
  assign pe_out_flit  = pe_out_flit_r;
  assign pe_out_valid = pe_out_valid_r;

  // Valid-bit vectors for the conservation checker.
  always_comb begin
    for (int i = 0; i < 6; i++) begin
      in_vld_s[i]   = in_s[i][VB];
      slot_vld_s[i] = slot_s[i][VB];
      s1_vld_s[i]   = s1_r[i][VB];
      out_vld_s[i]  = out_s[i][VB];
    end
  end

  chipper3d_pipe_router_chk u_chk (
    .clk      (clk),
    .rst      (rst),
    .in_vld   (in_vld_s),
    .slot_vld (slot_vld_s),
    .ej       (ej_found_s),
    .inj      (inj_s),
    .s1_vld   (s1_vld_s),
    .out_vld  (out_vld_s)
  );

endmodule

// File: tb/tb_chipper3d_pipe_router.sv
// Testbench for chipper3d_pipe_router (CW=2, PW=16, AGE_W=4, node (1,1,1)).
// Directed vector table, hand-written FIFO/reset sequences, then random
// traffic checked every cycle against a queue-based reference model.
module tb_chipper3d_pipe_router;

  localparam int FW    = 27;
  localparam int AL    = 22;
  localparam int VB    = 26;
  localparam int DEPTH = 4;

  typedef logic [FW-1:0] flit_t;

  typedef struct packed {
    logic [5:0][FW-1:0] vi;
    logic [5:0][FW-1:0] vo;
    logic               pv;
    logic [FW-1:0]      pf;
  } vec_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  flit_t         vin  [6];
  flit_t         vout [6];
  logic [FW-2:0] pe_in_flit = '0;
  logic          pe_in_valid = 1'b0;
  logic          pe_in_ready;
  flit_t         pe_out_flit;
  logic          pe_out_valid;
  flit_t         n_out, s_out, e_out, w_out, u_out, d_out;

  int checks   = 0;
  int failures = 0;

  // reference model state
  flit_t         m_s1  [6];
  flit_t         m_out [6];
  flit_t         m_pe_flit;
  logic          m_pe_vld;
  logic [AL-1:0] m_q [$];

  vec_t          vecs [6];
  logic [15:0]   pp   [4];

  always #5 clk = ~clk;

  chipper3d_pipe_router #(
    .CW(2), .PW(16), .AGE_W(4), .XN(2'd1), .YN(2'd1), .ZN(2'd1), .INJ_DEPTH(4)
  ) dut (
    .clk(clk), .rst(rst),
    .n_in(vin[0]), .s_in(vin[1]), .e_in(vin[2]), .w_in(vin[3]), .u_in(vin[4]), .d_in(vin[5]),
    .n_out(n_out), .s_out(s_out), .e_out(e_out), .w_out(w_out), .u_out(u_out), .d_out(d_out),
    .pe_in_flit(pe_in_flit), .pe_in_valid(pe_in_valid), .pe_in_ready(pe_in_ready),
    .pe_out_flit(pe_out_flit), .pe_out_valid(pe_out_valid)
  );

  assign vout[0] = n_out;
  assign vout[1] = s_out;
  assign vout[2] = e_out;
  assign vout[3] = w_out;
  assign vout[4] = u_out;
  assign vout[5] = d_out;

  function automatic flit_t mk(input int v, input int a, input int x, input int y,
                               input int z, input int p);
    return {1'(v), 4'(a), 2'(x), 2'(y), 2'(z), 16'(p)};
  endfunction

  function automatic int age_of(input flit_t f);
    return int'(f[25:22]);
  endfunction

  function automatic bit is_home(input flit_t f);
    return (f[21:20] == 2'd1) && (f[19:18] == 2'd1) && (f[17:16] == 2'd1);
  endfunction

  // YZX routing from the node (1,1,1); -1 means the flit is already home.
  function automatic int want(input flit_t f);
    int x, y, z;
    x = int'(f[21:20]);
    y = int'(f[19:18]);
    z = int'(f[17:16]);
    if (y > 1) return 0;
    if (y < 1) return 1;
    if (z > 1) return 4;
    if (z < 1) return 5;
    if (x > 1) return 2;
    if (x < 1) return 3;
    return -1;
  endfunction

  function automatic flit_t older(input flit_t f);
    flit_t r;
    int a;
    r = f;
    a = age_of(f) + 1;
    if (a > 15) a = 15;
    r[25:22] = 4'(a);
    return r;
  endfunction

  // Advance the reference model by one clock edge using the inputs now driven.
  function automatic void model_edge();
    flit_t      ns1  [6];
    flit_t      nout [6];
    logic [5:0] taken;
    logic [5:0] used;
    int         best, port, sz;
    bit         push;
    logic [AL-1:0] head;
    if (rst) begin
      for (int i = 0; i < 6; i++) begin
        m_s1[i]  = '0;
        m_out[i] = '0;
      end
      m_pe_flit = '0;
      m_pe_vld  = 1'b0;
      m_q.delete();
      return;
    end
    // link allocation of what sits in stage 1, oldest first
    taken = '0;
    used  = '0;
    for (int i = 0; i < 6; i++) nout[i] = '0;
    for (int k = 0; k < 6; k++) begin
      best = -1;
      for (int i = 0; i < 6; i++) begin
        if (m_s1[i][VB] && !taken[i]) begin
          if (best < 0 || age_of(m_s1[i]) > age_of(m_s1[best])) best = i;
        end
      end
      if (best >= 0) begin
        taken[best] = 1'b1;
        port = want(m_s1[best]);
        if (port < 0 || used[port]) begin
          port = -1;
          for (int q = 0; q < 6; q++) begin
            if (port < 0 && !used[q]) port = q;
          end
        end
        used[port] = 1'b1;
        nout[port] = older(m_s1[best]);
      end
    end
    // ejection and injection of the arriving flits
    sz   = m_q.size();
    push = pe_in_valid && (sz < DEPTH);
    for (int i = 0; i < 6; i++) ns1[i] = vin[i][VB] ? vin[i] : '0;
    best = -1;
    for (int i = 0; i < 6; i++) begin
      if (ns1[i][VB] && is_home(ns1[i])) begin
        if (best < 0 || age_of(ns1[i]) > age_of(ns1[best])) best = i;
      end
    end
    m_pe_vld  = (best >= 0);
    m_pe_flit = (best >= 0) ? ns1[best] : '0;
    if (best >= 0) ns1[best] = '0;
    if (sz > 0) begin
      for (int i = 0; i < 6; i++) begin
        if (!ns1[i][VB]) begin
          head   = m_q.pop_front();
          ns1[i] = {1'b1, 4'd0, head};
          break;
        end
      end
    end
    if (push) m_q.push_back(pe_in_flit[AL-1:0]);
    for (int i = 0; i < 6; i++) begin
      m_s1[i]  = ns1[i];
      m_out[i] = nout[i];
    end
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cmp_model();
    for (int i = 0; i < 6; i++) check($sformatf("model_out%0d", i), 64'(vout[i]), 64'(m_out[i]));
    check("model_pe_valid", 64'(pe_out_valid), 64'(m_pe_vld));
    if (m_pe_vld) check("model_pe_flit", 64'(pe_out_flit), 64'(m_pe_flit));
    check("model_ready", 64'(pe_in_ready), 64'((m_q.size() < DEPTH) && !rst));
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
    cmp_model();
  endtask

  function automatic int nvalid();
    int c;
    c = 0;
    for (int i = 0; i < 6; i++) if (vout[i][VB]) c++;
    return c;
  endfunction

  task automatic clear_in();
    for (int i = 0; i < 6; i++) vin[i] = '0;
  endtask

  function automatic flit_t rnd_flit();
    int x, y, z;
    x = $urandom_range(3, 0);
    y = $urandom_range(3, 0);
    z = $urandom_range(3, 0);
    if ($urandom_range(3, 0) == 0) begin
      x = 1; y = 1; z = 1;
    end
    return mk($urandom_range(1, 0), $urandom_range(15, 0), x, y, z, $urandom_range(65535, 0));
  endfunction

  initial begin
    int found;
    logic [15:0] pay;

    // directed vectors: inputs for one cycle; pe_out next cycle, links one cycle later
    for (int k = 0; k < 6; k++) vecs[k] = '0;
    vecs[0].vi[0] = mk(1, 0, 1, 3, 1, 16'hBEEF);
    vecs[0].vo[0] = mk(1, 1, 1, 3, 1, 16'hBEEF);
    vecs[1].vi[2] = mk(1, 5, 1, 3, 1, 16'h1111);
    vecs[1].vi[3] = mk(1, 2, 1, 3, 1, 16'h2222);
    vecs[1].vo[0] = mk(1, 6, 1, 3, 1, 16'h1111);
    vecs[1].vo[1] = mk(1, 3, 1, 3, 1, 16'h2222);
    vecs[2].vi[1] = mk(1, 1, 1, 1, 1, 16'h3333);
    vecs[2].vi[4] = mk(1, 7, 1, 1, 1, 16'h4444);
    vecs[2].pv    = 1'b1;
    vecs[2].pf    = mk(1, 7, 1, 1, 1, 16'h4444);
    vecs[2].vo[0] = mk(1, 2, 1, 1, 1, 16'h3333);
    vecs[3].vi[5] = mk(1, 15, 0, 1, 1, 16'h5555);
    vecs[3].vi[2] = mk(1, 3, 1, 1, 2, 16'h6666);
    vecs[3].vi[1] = mk(1, 0, 3, 1, 0, 16'h9999);
    vecs[3].vo[3] = mk(1, 15, 0, 1, 1, 16'h5555);
    vecs[3].vo[4] = mk(1, 4, 1, 1, 2, 16'h6666);
    vecs[3].vo[5] = mk(1, 1, 3, 1, 0, 16'h9999);
    vecs[4].vi[0] = mk(1, 4, 1, 0, 1, 16'h7777);
    vecs[4].vi[1] = mk(1, 4, 1, 0, 1, 16'h8888);
    vecs[4].vo[1] = mk(1, 5, 1, 0, 1, 16'h7777);
    vecs[4].vo[0] = mk(1, 5, 1, 0, 1, 16'h8888);
    vecs[5].vi[2] = mk(1, 2, 1, 1, 1, 16'hAAAA);
    vecs[5].vi[5] = mk(1, 2, 1, 1, 1, 16'hBBBB);
    vecs[5].pv    = 1'b1;
    vecs[5].pf    = mk(1, 2, 1, 1, 1, 16'hAAAA);
    vecs[5].vo[0] = mk(1, 3, 1, 1, 1, 16'hBBBB);
    pp[0] = 16'hC001; pp[1] = 16'hC002; pp[2] = 16'hC003; pp[3] = 16'hC004;

    // reset state
    clear_in();
    rst = 1'b1;
    step();
    step();
    check("reset_ready", 64'(pe_in_ready), 64'd0);
    check("reset_pe_valid", 64'(pe_out_valid), 64'd0);
    check("reset_nvalid", 64'(nvalid()), 64'd0);
    rst = 1'b0;
    step();
    check("ready_after_reset", 64'(pe_in_ready), 64'd1);

    // table
    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 6; i++) vin[i] = vecs[k].vi[i];
      step();
      check($sformatf("vec%0d_pe_valid", k), 64'(pe_out_valid), 64'(vecs[k].pv));
      if (vecs[k].pv) check($sformatf("vec%0d_pe_flit", k), 64'(pe_out_flit), 64'(vecs[k].pf));
      clear_in();
      step();
      for (int i = 0; i < 6; i++)
        check($sformatf("vec%0d_out%0d", k, i), 64'(vout[i]), 64'(vecs[k].vo[i]));
    end

    // injection into the only empty slot
    for (int i = 0; i < 5; i++) vin[i] = mk(1, 0, 2, 1, 1, 16'h4000 + i);
    pe_in_flit  = {4'd0, 2'd0, 2'd1, 2'd1, 16'hABCD};
    pe_in_valid = 1'b1;
    step();
    pe_in_valid = 1'b0;
    step();
    clear_in();
    step();
    found = 0;
    for (int i = 0; i < 6; i++)
      if (vout[i][VB] && vout[i][15:0] == 16'hABCD && vout[i][25:22] == 4'd1) found = 1;
    check("inject_age1_seen", 64'(found), 64'd1);
    step();
    step();

    // FIFO fills while every slot is busy; a fifth push is refused
    for (int i = 0; i < 6; i++) vin[i] = mk(1, 0, 2, 1, 1, 16'h5000 + i);
    pe_in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      pe_in_flit = {4'd0, 2'd1, 2'd1, 2'd0, pp[k]};
      step();
      check("full_links_six", 64'(nvalid()), 64'(k == 0 ? 0 : 6));
    end
    check("fifo_full_ready", 64'(pe_in_ready), 64'd0);
    pe_in_flit = {4'd0, 2'd1, 2'd1, 2'd0, 16'hC005};
    step();
    check("fifo_refuse_ready", 64'(pe_in_ready), 64'd0);
    pe_in_valid = 1'b0;
    clear_in();
    step();
    for (int k = 0; k < 4; k++) begin
      step();
      pay = '0;
      for (int i = 0; i < 6; i++) if (vout[i][VB]) pay = vout[i][15:0];
      check("drain_count", 64'(nvalid()), 64'd1);
      check("drain_order", 64'(pay), 64'(pp[k]));
    end
    step();
    check("drain_no_fifth", 64'(nvalid()), 64'd0);

    // reset mid-stream with three queued flits and a local flit arriving
    for (int i = 0; i < 6; i++) vin[i] = mk(1, 0, 2, 1, 1, 16'h6000 + i);
    pe_in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      pe_in_flit = {4'd0, 2'd1, 2'd1, 2'd0, 16'hD000 + 16'(k)};
      step();
    end
    pe_in_valid = 1'b0;
    vin[0] = mk(1, 3, 1, 1, 1, 16'hEEEE);
    rst = 1'b1;
    step();
    check("midrst_nvalid", 64'(nvalid()), 64'd0);
    check("midrst_pe_valid", 64'(pe_out_valid), 64'd0);
    check("midrst_ready", 64'(pe_in_ready), 64'd0);
    rst = 1'b0;
    clear_in();
    step();
    check("postrst_ready", 64'(pe_in_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      step();
      check("postrst_no_stale", 64'(nvalid() + int'(pe_out_valid)), 64'd0);
    end

    // random traffic against the model
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 6; i++) vin[i] = rnd_flit();
      pe_in_valid = ($urandom_range(2, 0) != 0);
      pe_in_flit  = FW'($urandom()) ;
      rst = ($urandom_range(99, 0) == 0);
      step();
    end
    rst = 1'b0;
    clear_in();
    pe_in_valid = 1'b0;
    for (int c = 0; c < 8; c++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
